// File: rtl/i2c_master_byte.sv
// Byte-level open-drain I2C master: START / WRITE / READ / STOP, one command per handshake.
// Optional I2C_CLK_STRETCH_EN: hold the quarter counter in Q1 while a slave stretches SCL.
module i2c_master_byte #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned I2C_FREQ_HZ = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] tx_data,
    input  logic       ack_send,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       nack,
    output logic       err,
    output logic       busy,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_out,
    output logic       scl_oe,
    output logic       sda_out,
    output logic       sda_oe
);

    localparam int unsigned QTR = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
    localparam int unsigned QW = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [QW-1:0] QLast = QW'(QTR - 1);

    localparam logic [1:0] CmdStart = 2'b00;
    localparam logic [1:0] CmdWrite = 2'b01;
    localparam logic [1:0] CmdRead  = 2'b10;
    localparam logic [1:0] CmdStop  = 2'b11;

    typedef enum logic [2:0] {StIdle, StStart, StBit, StAck, StStop, StErr} state_e;

    state_e        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    q_q, q_d;
    logic [2:0]    bit_q, bit_d;
    logic          rep_q, rep_d, rd_q, rd_d, acks_q, acks_d;
    logic [7:0]    shift_q, shift_d, rx_q, rx_d;
    logic          nack_q, nack_d, err_q, err_d, busy_q, busy_d;
    logic          hold_q, hold_d, done_q, done_d;
    logic          accept, stall, qend, last_qtr;

    assign cmd_ready = (state_q == StIdle);
    assign accept    = cmd_valid && cmd_ready;

`ifdef I2C_CLK_STRETCH_EN
    assign stall = (state_q != StIdle) && (state_q != StErr) && (q_q == 2'd1) && !scl_oe && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign stall = 1'b0;
`endif

    assign qend     = (qcnt_q == QLast) && !stall;
    // A START from a free bus needs only three quarters.
    assign last_qtr = (state_q == StStart && !rep_q) ? (q_q == 2'd2) : (q_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            qcnt_q  <= '0;
            q_q     <= '0;
            bit_q   <= '0;
            rep_q   <= 1'b0;
            rd_q    <= 1'b0;
            acks_q  <= 1'b0;
            shift_q <= '0;
            rx_q    <= '0;
            nack_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            q_q     <= q_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
            rd_q    <= rd_d;
            acks_q  <= acks_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            nack_q  <= nack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (cmd)
                        CmdStart:          state_d = StStart;
                        CmdWrite, CmdRead: state_d = busy_q ? StBit : StErr;
                        CmdStop:           state_d = busy_q ? StStop : StErr;
                    endcase
                end
            end
            StStart, StAck, StStop: if (qend && last_qtr) state_d = StIdle;
            StBit: if (qend && q_q == 2'd3 && bit_q == 3'd7) state_d = StAck;
            StErr: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin : dp_next
        qcnt_d  = qcnt_q;
        q_d     = q_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        rd_d    = rd_q;
        acks_d  = acks_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        nack_d  = nack_q;
        err_d   = err_q;
        busy_d  = busy_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        if (state_q == StIdle) begin
            if (accept) begin
                rep_d   = busy_q;
                rd_d    = (cmd == CmdRead);
                acks_d  = ack_send;
                shift_d = tx_data;
            end
        end else if (state_q != StErr) begin
            if (qend) begin
                qcnt_d = '0;
                q_d    = q_q + 2'd1;
                if (state_q == StBit && q_q == 2'd3) bit_d = bit_q + 3'd1;
            end else if (!stall) begin
                qcnt_d = qcnt_q + QW'(1);
            end
            // One register serves as TX shifter, RX shifter and WRITE ack capture.
            if (qend && q_q == 2'd1 && ((state_q == StBit && rd_q) || (state_q == StAck && !rd_q)))
                shift_d = {shift_q[6:0], sda_in};
            if (qend && q_q == 2'd3 && state_q == StBit && !rd_q)
                shift_d = {shift_q[6:0], 1'b0};
        end
        if (state_q != StIdle && state_d == StIdle) begin
            done_d = 1'b1;
            err_d  = (state_q == StErr);
            qcnt_d = '0;
            q_d    = '0;
            bit_d  = '0;
            if (state_q == StStart) begin
                busy_d = 1'b1;
                hold_d = 1'b1;
            end
            if (state_q == StAck) begin
                hold_d = 1'b0;
                if (rd_q) rx_d = shift_q;
                else      nack_d = shift_q[0];
            end
            if (state_q == StStop) begin
                busy_d = 1'b0;
                hold_d = 1'b0;
            end
        end
    end

    always_comb begin : pad_out
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        unique case (state_q)
            StStart: begin
                if (rep_q) begin
                    scl_oe = (q_q == 2'd0) || (q_q == 2'd3);
                    sda_oe = (q_q >= 2'd2);
                end else begin
                    scl_oe = (q_q >= 2'd2);
                    sda_oe = (q_q >= 2'd1);
                end
            end
            StBit: begin
                scl_oe = (q_q == 2'd0) || (q_q == 2'd3);
                sda_oe = rd_q ? 1'b0 : ~shift_q[7];
            end
            StAck: begin
                scl_oe = (q_q == 2'd0) || (q_q == 2'd3);
                sda_oe = rd_q ? ~acks_q : 1'b0;
            end
            StStop: begin
                scl_oe = (q_q == 2'd0);
                sda_oe = (q_q <= 2'd1);
            end
            default: begin
                // Between commands the bus keeps SCL low while owned.
                scl_oe = busy_q;
                sda_oe = hold_q;
            end
        endcase
    end

    assign scl_out = 1'b0;
    assign sda_out = 1'b0;
    assign done    = done_q;
    assign rx_data = rx_q;
    assign nack    = nack_q;
    assign err     = err_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Self-checking bench for i2c_master_byte: open-drain pad and slave model, transaction-level
// reference of flags, latency and the bit stream seen on the bus.
`timescale 1ns/1ps
module tb_i2c_master_byte;

    localparam int unsigned QTR = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] tx_data = 8'h00;
    logic       ack_send = 1'b0;
    logic       cmd_ready, done, nack, err, busy;
    logic [7:0] rx_data;
    logic       scl_in, sda_in, scl_out, scl_oe, sda_out, sda_oe;

    always #5 clk = ~clk;

    i2c_master_byte #(.CLK_FREQ_HZ(4_000_000), .I2C_FREQ_HZ(100_000)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .tx_data(tx_data), .ack_send(ack_send), .done(done), .rx_data(rx_data), .nack(nack),
        .err(err), .busy(busy), .scl_in(scl_in), .sda_in(sda_in), .scl_out(scl_out),
        .scl_oe(scl_oe), .sda_out(sda_out), .sda_oe(sda_oe)
    );

    // Bus: wired-AND of master and slave pull-downs.
    logic       stretch = 1'b0;
    logic       slv_pull;
    int         slv_mode = 0;
    logic [7:0] slv_byte = 8'h00;
    int         fall_base = 0;
    int         slv_k;
    logic       scl_line, sda_line;
    assign scl_line = ~scl_oe & ~stretch;
    assign sda_line = ~(sda_oe | slv_pull);
    assign scl_in   = scl_line;
    assign sda_in   = sda_line;

    logic bits_q[$];
    int   falls = 0, starts = 0, stops = 0;
    logic scl_prev = 1'b1, sda_prev = 1'b1;

    // Slave: mode 1 ACKs a written byte, mode 2 returns slv_byte MSB first.
    always_comb begin
        slv_k = falls - fall_base;
        slv_pull = 1'b0;
        if (slv_mode == 2 && slv_k >= 0 && slv_k < 8) slv_pull = ~slv_byte[7 - slv_k];
        else if (slv_mode == 1 && slv_k == 8) slv_pull = 1'b1;
    end

    always @(negedge clk) begin
        if (scl_line === 1'b1 && scl_prev === 1'b0) bits_q.push_back(sda_line);
        if (scl_line === 1'b0 && scl_prev === 1'b1) falls <= falls + 1;
        if (scl_line === 1'b1 && scl_prev === 1'b1 && sda_prev === 1'b1 && sda_line === 1'b0)
            starts <= starts + 1;
        if (scl_line === 1'b1 && scl_prev === 1'b1 && sda_prev === 1'b0 && sda_line === 1'b1)
            stops <= stops + 1;
        scl_prev <= scl_line;
        sda_prev <= sda_line;
    end

    int         n_chk = 0, n_fail = 0;
    logic       busy_m = 1'b0, err_m = 1'b0, nack_m = 1'b0, hold_m = 1'b0;
    logic [7:0] rx_m = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] c, input logic [7:0] d, input logic a_send,
                          input logic s_ack, input int strc);
        logic       illegal, trig;
        int         exp_lat, n, bbase, sbase, pbase, scnt;
        logic [8:0] exp_bits, got;
        string      nm;
        nm = (c == 2'b00) ? "START" : (c == 2'b01) ? "WRITE" : (c == 2'b10) ? "READ" : "STOP";
        illegal = (c != 2'b00) && !busy_m;
        if (illegal)           exp_lat = 1;
        else if (c == 2'b00)   exp_lat = busy_m ? 4 * QTR : 3 * QTR;
        else if (c == 2'b11)   exp_lat = 4 * QTR;
        else                   exp_lat = 36 * QTR + strc;
        exp_bits = (c == 2'b01) ? {d, ~s_ack} : {d, a_send};
        slv_mode = illegal ? 0 : (c == 2'b01 && s_ack) ? 1 : (c == 2'b10) ? 2 : 0;
        slv_byte = d;
        fall_base = falls;
        bbase = bits_q.size();
        sbase = starts;
        pbase = stops;
        @(negedge clk);
        cmd = c;
        tx_data = (c == 2'b10) ? ~d : d;
        ack_send = a_send;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        tx_data = 8'($urandom);
        ack_send = ~a_send;
        check({nm, " ready_drop"}, 32'(cmd_ready), 32'(1'b0));
        n = 0;
        trig = (strc > 0);
        scnt = 0;
        while (n < 2000) begin
            @(posedge clk);
            n++;
            #1;
            if (trig && !scl_oe) begin
                stretch = 1'b1;
                scnt = strc;
                trig = 1'b0;
            end else if (stretch) begin
                scnt--;
                if (scnt == 0) stretch = 1'b0;
            end
            if (done === 1'b1) break;
        end
        stretch = 1'b0;
        check({nm, " latency"}, 32'(n), 32'(exp_lat));
        check({nm, " ready_on_done"}, 32'(cmd_ready), 32'(1'b1));
        if (illegal) begin
            err_m = 1'b1;
        end else begin
            err_m = 1'b0;
            unique case (c)
                2'b00: begin busy_m = 1'b1; hold_m = 1'b1; end
                2'b01: begin nack_m = ~s_ack; hold_m = 1'b0; end
                2'b10: begin rx_m = d; hold_m = 1'b0; end
                2'b11: begin busy_m = 1'b0; hold_m = 1'b0; end
            endcase
        end
        @(negedge clk);
        check({nm, " err"}, 32'(err), 32'(err_m));
        check({nm, " nack"}, 32'(nack), 32'(nack_m));
        check({nm, " busy"}, 32'(busy), 32'(busy_m));
        check({nm, " rx_data"}, 32'(rx_data), 32'(rx_m));
        check({nm, " idle_scl_oe"}, 32'(scl_oe), 32'(busy_m));
        check({nm, " idle_sda_oe"}, 32'(sda_oe), 32'(hold_m));
        check({nm, " starts"}, 32'(starts - sbase), 32'(!illegal && c == 2'b00));
        check({nm, " stops"}, 32'(stops - pbase), 32'(!illegal && c == 2'b11));
        if (!illegal && (c == 2'b01 || c == 2'b10)) begin
            check({nm, " bit_count"}, 32'(bits_q.size() - bbase), 32'd9);
            got = '0;
            for (int i = 0; i < 9; i++)
                if (bbase + i < bits_q.size()) got = {got[7:0], bits_q[bbase + i]};
            check({nm, " bus_bits"}, 32'(got), 32'(exp_bits));
        end
        @(posedge clk);
        #1;
        check({nm, " done_pulse"}, 32'(done), 32'(1'b0));
        slv_mode = 0;
    endtask

    initial begin
        logic [1:0] c;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst scl_oe", 32'(scl_oe), 32'(1'b0));
        check("rst sda_oe", 32'(sda_oe), 32'(1'b0));
        check("rst cmd_ready", 32'(cmd_ready), 32'(1'b1));
        check("rst done", 32'(done), 32'(1'b0));
        check("rst rx_data", 32'(rx_data), 32'd0);
        check("rst nack", 32'(nack), 32'(1'b0));
        check("rst err", 32'(err), 32'(1'b0));
        check("rst busy", 32'(busy), 32'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        do_cmd(2'b01, 8'h12, 1'b0, 1'b1, 0);      // WRITE with bus free
        do_cmd(2'b00, 8'h00, 1'b0, 1'b0, 0);
        do_cmd(2'b01, 8'hA0, 1'b0, 1'b1, 0);
        do_cmd(2'b01, 8'h3C, 1'b0, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            c = 2'($urandom_range(1, 2));
            do_cmd(c, 8'($urandom), 1'($urandom), 1'($urandom), 0);
        end
        do_cmd(2'b10, 8'h5C, 1'b0, 1'b0, 0);
        do_cmd(2'b01, 8'($urandom), 1'b0, 1'b1, 0);  // rx_data must hold across a WRITE
        do_cmd(2'b00, 8'h00, 1'b0, 1'b0, 0);      // repeated START
        do_cmd(2'b10, 8'($urandom), 1'b1, 1'b0, 0);
        do_cmd(2'b11, 8'h00, 1'b0, 1'b0, 0);
        do_cmd(2'b01, 8'h55, 1'b0, 1'b1, 0);
        do_cmd(2'b10, 8'h66, 1'b0, 1'b0, 0);
        do_cmd(2'b11, 8'h00, 1'b0, 1'b0, 0);
        do_cmd(2'b00, 8'h00, 1'b0, 1'b0, 0);
        do_cmd(2'b00, 8'h00, 1'b0, 1'b0, 0);      // repeated START straight after START
        do_cmd(2'b11, 8'h00, 1'b0, 1'b0, 0);
`ifdef I2C_CLK_STRETCH_EN
        do_cmd(2'b00, 8'h00, 1'b0, 1'b0, 0);
        do_cmd(2'b01, 8'($urandom), 1'b0, 1'b1, 50);
        do_cmd(2'b11, 8'h00, 1'b0, 1'b0, 0);
`endif

        // Reset in bit 3 (Q0) of a WRITE of 0xA5: that bit is 0, so both pins are pulled.
        do_cmd(2'b00, 8'h00, 1'b0, 1'b0, 0);
        @(negedge clk);
        cmd = 2'b01;
        tx_data = 8'hA5;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (125) @(posedge clk);
        #2;
        check("midrst pre scl_oe", 32'(scl_oe), 32'(1'b1));
        check("midrst pre sda_oe", 32'(sda_oe), 32'(1'b1));
        rst_n = 1'b0;
        #1;
        check("midrst scl_oe", 32'(scl_oe), 32'(1'b0));
        check("midrst sda_oe", 32'(sda_oe), 32'(1'b0));
        check("midrst cmd_ready", 32'(cmd_ready), 32'(1'b1));
        check("midrst busy", 32'(busy), 32'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        busy_m = 1'b0;
        err_m = 1'b0;
        nack_m = 1'b0;
        hold_m = 1'b0;
        rx_m = 8'h00;
        @(negedge clk);
        check("midrst rx_data", 32'(rx_data), 32'd0);
        check("midrst done", 32'(done), 32'(1'b0));
        do_cmd(2'b00, 8'h00, 1'b0, 1'b0, 0);
        do_cmd(2'b11, 8'h00, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
